// File: rtl/divmod_dp.sv
// divmod_dp: radix-2 restoring mantissa divider for the FPU.
// One quotient bit per unheld cycle; WIDTH+2 quotient bits plus a sticky bit.
// fpuhold freezes every register; reset aborts any operation in flight.
module divmod_dp #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fpuhold,
    input  logic             start,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic             busy,
    output logic             done,
    output logic [WIDTH+1:0] quot,
    output logic             sticky,
    output logic             qovf,
    output logic             derr
);

    // Counter must hold WIDTH+2 iterations.
    localparam int CW = $clog2(WIDTH + 3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH:0]   rem_reg;      // partial remainder, WIDTH+1 bits
    logic [WIDTH-1:0] dvs_reg;      // divisor captured at start
    logic [WIDTH+1:0] quot_reg;     // quotient shift register
    logic [CW-1:0]    count_reg;
    logic             sticky_reg;
    logic             qovf_reg;
    logic             derr_reg;
    logic             busy_reg;
    logic             done_reg;

    // Trial subtraction R - {0,dvs} as an explicit borrow chain; the final
    // borrow doubles as the comparison (no borrow means R >= dvs).
    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] borrow;
    logic             qbit;
    logic [WIDTH:0]   rem_sel;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH+1:0] quot_next;

    assign dvs_ext   = {1'b0, dvs_reg};
    assign borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
            assign diff[gi]       = rem_reg[gi] ^ dvs_ext[gi] ^ borrow[gi];
            assign borrow[gi + 1] = (~rem_reg[gi] & dvs_ext[gi]) |
                                    (~(rem_reg[gi] ^ dvs_ext[gi]) & borrow[gi]);
        end
    endgenerate

    assign qbit      = ~borrow[WIDTH + 1];
    assign rem_sel   = qbit ? diff : rem_reg;
    // R' < dvs < 2^WIDTH, so the shifted value always fits in WIDTH+1 bits.
    assign rem_next  = rem_sel << 1;
    assign quot_next = {quot_reg[WIDTH:0], qbit};

    // Control FSM and datapath registers; everything frozen while fpuhold is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            rem_reg    <= '0;
            dvs_reg    <= '0;
            quot_reg   <= '0;
            count_reg  <= '0;
            sticky_reg <= 1'b0;
            qovf_reg   <= 1'b0;
            derr_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else if (!fpuhold) begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        quot_reg   <= '0;
                        sticky_reg <= 1'b0;
                        qovf_reg   <= 1'b0;
                        if (!dvs[WIDTH-1]) begin
                            // Unnormalized divisor: report immediately, no iterations.
                            derr_reg  <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            rem_reg   <= {1'b0, dvd};
                            dvs_reg   <= dvs;
                            count_reg <= CW'(WIDTH + 2);
                            derr_reg  <= 1'b0;
                            busy_reg  <= 1'b1;
                            state_reg <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_reg   <= rem_next;
                    quot_reg  <= quot_next;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == CW'(1)) begin
                        // Last iteration: capture the flags from the final values.
                        sticky_reg <= (rem_next != '0);
                        qovf_reg   <= quot_next[WIDTH+1];
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign quot   = quot_reg;
    assign sticky = sticky_reg;
    assign qovf   = qovf_reg;
    assign derr   = derr_reg;

endmodule

// File: tb/tb_divmod_dp.sv
// tb_divmod_dp: scoreboard bench for divmod_dp (WIDTH=24).
// The driver pushes the expected result and completion cycle per accepted
// start; a negedge monitor pops and compares whenever done rises.
module tb_divmod_dp;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         fpuhold = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dvd = '0;
    logic [W-1:0] dvs = '0;
    logic         busy;
    logic         done;
    logic [W+1:0] quot;
    logic         sticky;
    logic         qovf;
    logic         derr;

    divmod_dp #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .fpuhold (fpuhold),
        .start   (start),
        .dvd     (dvd),
        .dvs     (dvs),
        .busy    (busy),
        .done    (done),
        .quot    (quot),
        .sticky  (sticky),
        .qovf    (qovf),
        .derr    (derr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W+1:0] quot;
        logic         sticky;
        logic         qovf;
        logic         derr;
        int           done_cyc;
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: quotient and remainder of dvd*2^(W+1) / dvs by plain arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [63:0] num;
        e.dvd = a;
        e.dvs = b;
        e.done_cyc = 0;
        if (b < (1 << (W - 1))) begin
            e.quot = '0; e.sticky = 1'b0; e.qovf = 1'b0; e.derr = 1'b1;
        end else begin
            num = 64'(a) * (64'd1 << (W + 1));
            e.quot   = (W+2)'(num / 64'(b));
            e.sticky = (num % 64'(b)) != 0;
            e.qovf   = (num / 64'(b)) >= (64'd1 << (W + 1));
            e.derr   = 1'b0;
        end
        return e;
    endfunction

    // Monitor: compare on each rising done; flag done/busy overlap.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy && done) check("busy_done_exclusive", 1, 0);
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("op dvd=%06h dvs=%06h quot=%07h sticky=%0d qovf=%0d derr=%0d cyc=%0d",
                         e.dvd, e.dvs, quot, sticky, qovf, derr, cyc);
                check("quot",   64'(quot),   64'(e.quot));
                check("sticky", 64'(sticky), 64'(e.sticky));
                check("qovf",   64'(qovf),   64'(e.qovf));
                check("derr",   64'(derr),   64'(e.derr));
                check("done_cycle", 64'(cyc), 64'(e.done_cyc));
            end
        end
        done_prev = done;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 1, 0);
    endtask

    // One divide: optional fpuhold burst of hold_len cycles after hold_after
    // RUN cycles, optionally followed by a start pulse that must be ignored.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold_after, input int hold_len, input bit pulse);
        exp_t e;
        int n;
        wait_idle();
        dvd = a; dvs = b; start = 1'b1;
        e = model(a, b);
        @(posedge clk);
        #1;
        e.done_cyc = e.derr ? cyc : cyc + W + 2 + hold_len;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (e.derr) check("derr_busy", 64'(busy), 64'(0));
        if (!e.derr && hold_len > 0) begin
            repeat (hold_after) @(negedge clk);
            fpuhold = 1'b1;
            repeat (hold_len) @(negedge clk);
            fpuhold = 1'b0;
        end
        if (!e.derr && pulse) begin
            start = 1'b1;
            dvd = ~a;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("done_timeout", 1, 0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        int ha, hl;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy",   64'(busy),   0);
        check("rst_done",   64'(done),   0);
        check("rst_quot",   64'(quot),   0);
        check("rst_sticky", 64'(sticky), 0);
        check("rst_qovf",   64'(qovf),   0);
        check("rst_derr",   64'(derr),   0);

        do_op(24'h800000, 24'h800000, 0, 0, 0);
        do_op(24'h800000, 24'hC00000, 0, 0, 0);
        do_op(24'hC00000, 24'h800000, 0, 0, 0);
        do_op(24'hFFFFFF, 24'h800000, 0, 0, 0);
        do_op(24'h000000, 24'h800000, 0, 0, 0);
        do_op(24'h900000, 24'h400000, 0, 0, 0);
        do_op(24'h900000, 24'h800000, 0, 0, 0);
        do_op(24'hABCDEF, 24'hFFFFFF, 6, 5, 1);

        // Reset at iteration 10 aborts; no done may follow.
        wait_idle();
        dvd = 24'hC00000; dvs = 24'h900000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 0);
        check("abort_done", 64'(done), 0);
        check("abort_quot", 64'(quot), 0);
        repeat (40) @(negedge clk);
        do_op(24'hC00000, 24'h900000, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            if ($urandom_range(7) == 0) a = '0;
            else if ($urandom_range(1) == 0) a[W-1] = 1'b1;
            b = W'($urandom);
            if ($urandom_range(9) == 0) b[W-1] = 1'b0;
            else b[W-1] = 1'b1;
            ha = $urandom_range(10);
            hl = ($urandom_range(2) == 0) ? $urandom_range(1, 6) : 0;
            do_op(a, b, ha, hl, $urandom_range(1) == 1);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
